pipeline_ctrl: RTL and testbench

Central sequencer for the four-stage CPU pipeline (IF, ID, EX/MEM, WB). It holds a register scoreboard of in-flight writes and decides each cycle whether to advance, stall or flush. It drives PC and IF/ID enables, IF/ID flush and the ID/EX bubble. It also runs the start/halt/drain state machine and counts stall cycles. It sits beside the control decoder and consumes decoded ID-stage fields, the EX/MEM redirect (PC-change) request and WB write-back info.

---
 rtl/pipeline_ctrl_pkg.sv | 36 +++
 rtl/pipeline_ctrl_reg_scoreboard.sv | 51 +++++
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM state encoding,
// the bundle of per-cycle pipeline control outputs, and default geometry.
package pipeline_ctrl_pkg;

   localparam int NREG_DEF         = 64;
   localparam int AW_DEF           = 6;
   localparam int CW_DEF           = 16;
   localparam int DRAIN_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_bubble;
      logic issue;
   } pipe_ctl_t;

   // Frozen pipe: nothing fetched, IF/ID and ID/EX held empty.
   function automatic pipe_ctl_t ctl_idle();
      pipe_ctl_t c;
      c.pc_en       = 1'b0;
      c.ifid_en     = 1'b0;
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
      c.issue       = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue of
// a writer and cleared on write-back; a set in the same cycle as a clear wins.
module reg_scoreboard
   import pipeline_ctrl_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   input  logic [AW-1:0]   rd_a_idx,
   input  logic [AW-1:0]   rd_b_idx,
   output logic            rd_a,
   output logic            rd_b,
   output logic            any_pending,
   output logic [NREG-1:0] pend_o
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   always_comb begin
      pend_d = pend_q;
      if (clr_en) begin
         pend_d[clr_idx] = 1'b0;
      end
      // The newer writer is still in flight, so its set overrides the clear.
      if (set_en) begin
         pend_d[set_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Reads see registered state only; the register file write lands at the edge.
   assign rd_a        = pend_q[rd_a_idx];
   assign rd_b        = pend_q[rd_b_idx];
   assign any_pending = |pend_q;
   assign pend_o      = pend_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: start/halt/drain FSM, RAW hazard stall via the
// register scoreboard, EX/MEM redirect flush, and a saturating stall counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int NREG         = NREG_DEF,
   parameter int AW           = AW_DEF,
   parameter int CW           = CW_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rs,
   input  logic [AW-1:0]   id_rt,
   input  logic            id_uses_rs,
   input  logic            id_uses_rt,
   input  logic [AW-1:0]   id_rd,
   input  logic            id_reg_wrt,
   input  logic            id_halt,
   input  logic            ex_redirect,
   input  logic            wb_reg_wrt,
   input  logic [AW-1:0]   wb_rd,
   output logic            pc_en,
   output logic            ifid_en,
   output logic            ifid_flush,
   output logic            idex_bubble,
   output logic            issue,
   output logic            running,
   output logic            done,
   output logic [CW-1:0]   stall_cycles,
   output state_e          dbg_state,
   output logic [NREG-1:0] dbg_pend
);

   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

   // Handshake: id_valid is the ID stage's valid, issue is the accept. An ID
   // instruction moves into ID/EX only in a cycle with id_valid=1 and issue=1;
   // while issue=0 the IF/ID buffer keeps (or flushes) it and id_* must hold.

   state_e          state_q, state_d;
   logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
   logic [CW-1:0]   stall_cycles_q, stall_cycles_d;
   pipe_ctl_t       ctl;

   logic            rs_pend;
   logic            rt_pend;
   logic            any_pending;
   logic            hazard;

   reg_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_en      (ctl.issue & id_reg_wrt),
      .set_idx     (id_rd),
      .clr_en      (wb_reg_wrt),
      .clr_idx     (wb_rd),
      .rd_a_idx    (id_rs),
      .rd_b_idx    (id_rt),
      .rd_a        (rs_pend),
      .rd_b        (rt_pend),
      .any_pending (any_pending),
      .pend_o      (dbg_pend)
   );

   assign hazard = id_valid & ((id_uses_rs & rs_pend) | (id_uses_rt & rt_pend));

   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      stall_cycles_d = stall_cycles_q;
      ctl            = ctl_idle();

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (ex_redirect) begin
               // Wrong-path fetch: squash IF/ID and the ID/EX slot, take new PC.
               ctl.pc_en   = 1'b1;
               ctl.ifid_en = 1'b1;
            end else if (hazard) begin
               ctl.ifid_flush = 1'b0;
               if (stall_cycles_q != '1) begin
                  stall_cycles_d = stall_cycles_q + CW'(1);
               end
            end else if (id_valid && id_halt) begin
               // Halt goes down the pipe; fetch stops and IF/ID is emptied behind it.
               ctl.issue       = 1'b1;
               ctl.ifid_en     = 1'b1;
               ctl.idex_bubble = 1'b0;
               state_d         = DRAIN;
               drain_cnt_d     = '0;
            end else begin
               ctl.pc_en       = 1'b1;
               ctl.ifid_en     = 1'b1;
               ctl.ifid_flush  = 1'b0;
               ctl.idex_bubble = !id_valid;
               ctl.issue       = id_valid;
            end
         end

         DRAIN: begin
            if (drain_cnt_q != DRAIN_LAST) begin
               drain_cnt_d = drain_cnt_q + DW'(1);
            end
            if ((drain_cnt_q == DRAIN_LAST) && !any_pending) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         drain_cnt_q    <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_cnt_q    <= drain_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign pc_en        = ctl.pc_en;
   assign ifid_en      = ctl.ifid_en;
   assign ifid_flush   = ctl.ifid_flush;
   assign idex_bubble  = ctl.idex_bubble;
   assign issue        = ctl.issue;
   assign running      = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign stall_cycles = stall_cycles_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

   localparam int NREG      = 64;
   localparam int AW        = 6;
   localparam int CW        = 16;
   localparam int DRAIN_N   = 2;
   localparam int STALL_MAX = (1 << CW) - 1;

   // Model state names are the bench's own, independent of the RTL encoding.
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            id_valid;
   logic [AW-1:0]   id_rs, id_rt, id_rd;
   logic            id_uses_rs, id_uses_rt;
   logic            id_reg_wrt, id_halt;
   logic            ex_redirect;
   logic            wb_reg_wrt;
   logic [AW-1:0]   wb_rd;
   logic            pc_en, ifid_en, ifid_flush, idex_bubble, issue;
   logic            running, done;
   logic [CW-1:0]   stall_cycles;
   pipeline_ctrl_pkg::state_e dbg_state;
   logic [NREG-1:0] dbg_pend;

   int n_checks = 0;
   int n_errors = 0;

   int        m_state;
   bit [63:0] m_pend;
   int        m_drain;
   int        m_stall;

   logic [5:0] exp_q[$];

   pipeline_ctrl #(
      .NREG         (NREG),
      .AW           (AW),
      .CW           (CW),
      .DRAIN_CYCLES (DRAIN_N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_rd        (id_rd),
      .id_reg_wrt   (id_reg_wrt),
      .id_halt      (id_halt),
      .ex_redirect  (ex_redirect),
      .wb_reg_wrt   (wb_reg_wrt),
      .wb_rd        (wb_rd),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .issue        (issue),
      .running      (running),
      .done         (done),
      .stall_cycles (stall_cycles),
      .dbg_state    (dbg_state),
      .dbg_pend     (dbg_pend)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = M_IDLE;
      m_pend  = '0;
      m_drain = 0;
      m_stall = 0;
   endfunction

   // Expected outputs from the current model state and current inputs.
   function automatic void model_out(output logic [5:0] v, output bit en_care,
                                     output bit en_exp, output bit haz, output bit iss);
      bit pc, fl, bub;
      pc = 0; fl = 1; bub = 1; iss = 0; en_exp = 0; en_care = 1;
      haz = id_valid && ((id_uses_rs && m_pend[id_rs]) || (id_uses_rt && m_pend[id_rt]));
      if (m_state == M_RUN) begin
         if (ex_redirect) begin
            pc = 1; en_exp = 1;
         end else if (haz) begin
            fl = 0;
         end else if (id_valid && id_halt) begin
            iss = 1; bub = 0; en_care = 0;
         end else begin
            pc = 1; en_exp = 1; fl = 0; bub = !id_valid; iss = id_valid;
         end
      end else if (m_state == M_DRAIN) begin
         en_care = 0;
      end
      v = {pc, fl, bub, iss, (m_state == M_RUN), (m_state == M_DONE)};
   endfunction

   function automatic void model_update(input bit haz, input bit iss);
      case (m_state)
         M_IDLE: if (start) m_state = M_RUN;
         M_RUN: begin
            if (!ex_redirect && haz) begin
               if (m_stall < STALL_MAX) m_stall++;
            end else if (!ex_redirect && id_valid && id_halt) begin
               m_state = M_DRAIN;
               m_drain = 0;
            end
         end
         M_DRAIN: begin
            if (m_drain == DRAIN_N && m_pend == 0) m_state = M_DONE;
            if (m_drain < DRAIN_N) m_drain++;
         end
         default: ;
      endcase
      if (wb_reg_wrt) m_pend[wb_rd] = 1'b0;
      if (iss && id_reg_wrt) m_pend[id_rd] = 1'b1;
   endfunction

   // ---------------- driver tasks ----------------
   // One clock: sample at negedge against the model, advance model, return at posedge+1.
   task automatic cycle(input string tag);
      logic [5:0] exp_v, got_v;
      bit en_care, en_exp, haz, iss;
      @(negedge clk);
      model_out(exp_v, en_care, en_exp, haz, iss);
      exp_q.push_back(exp_v);
      got_v = {pc_en, ifid_flush, idex_bubble, issue, running, done};
      chk({tag, ":ctl"}, 64'(got_v), 64'(exp_q.pop_front()));
      if (en_care) chk({tag, ":ifid_en"}, 64'(ifid_en), 64'(en_exp));
      chk({tag, ":stall"}, 64'(stall_cycles), 64'(m_stall));
      chk({tag, ":pend"}, 64'(dbg_pend), m_pend);
      model_update(haz, iss);
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input bit v, input int rs, input bit urs, input int rt,
                         input bit urt, input int rd, input bit wrt, input bit hlt);
      id_valid   = v;
      id_rs      = AW'(rs);
      id_uses_rs = urs;
      id_rt      = AW'(rt);
      id_uses_rt = urt;
      id_rd      = AW'(rd);
      id_reg_wrt = wrt;
      id_halt    = hlt;
   endtask

   task automatic set_wb(input bit en, input int rd);
      wb_reg_wrt = en;
      wb_rd      = AW'(rd);
   endtask

   // Asynchronous reset asserted away from the edge, checked before any clock.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, ":rst_running"}, 64'(running), 64'(0));
      chk({tag, ":rst_pc_en"}, 64'(pc_en), 64'(0));
      chk({tag, ":rst_bubble"}, 64'(idex_bubble), 64'(1));
      chk({tag, ":rst_stall"}, 64'(stall_cycles), 64'(0));
      chk({tag, ":rst_pend"}, 64'(dbg_pend), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic start_run();
      start = 1'b1;
      cycle("start");
      start = 1'b0;
   endtask

   int sat_base;

   initial begin
      rst_n = 1'b0; start = 1'b0; ex_redirect = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0);
      model_reset();
      #12;
      do_reset("init");

      // Start handshake
      cycle("idle");
      chk("pre_start_pc_en", 64'(pc_en), 64'(0));
      chk("pre_start_bubble", 64'(idex_bubble), 64'(1));
      start_run();
      chk("post_start_running", 64'(running), 64'(1));
      chk("post_start_pc_en", 64'(pc_en), 64'(1));

      // Back-to-back RAW on r5
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      cycle("w5");
      set_id(1, 5, 1, 0, 0, 0, 0, 0);
      #1;
      chk("raw_stall1_issue", 64'(issue), 64'(0));
      chk("raw_stall1_pc_en", 64'(pc_en), 64'(0));
      cycle("raw_s1");
      set_wb(1, 5);
      #1;
      chk("raw_stall2_issue", 64'(issue), 64'(0));
      cycle("raw_s2");
      set_wb(0, 0);
      #1;
      chk("raw_resume_issue", 64'(issue), 64'(1));
      chk("raw_stall_count", 64'(stall_cycles), 64'(2));
      cycle("raw_go");

      // Set and clear of r7 in the same cycle
      set_id(1, 0, 0, 0, 0, 7, 1, 0);
      cycle("w7a");
      set_wb(1, 7);
      cycle("w7b_clr7");
      set_wb(0, 0);
      set_id(1, 0, 0, 7, 1, 0, 0, 0);
      #1;
      chk("setclr_pend7", 64'(dbg_pend[7]), 64'(1));
      chk("setclr_reader_stall", 64'(issue), 64'(0));
      cycle("r7_stall");
      set_wb(1, 7);
      cycle("r7_wb");
      set_wb(0, 0);
      cycle("r7_go");

      // Redirect overrides a pending hazard
      set_id(1, 0, 0, 0, 0, 9, 1, 0);
      cycle("w9");
      set_id(1, 9, 1, 0, 0, 0, 0, 0);
      ex_redirect = 1'b1;
      sat_base = m_stall;
      #1;
      chk("redir_pc_en", 64'(pc_en), 64'(1));
      chk("redir_flush", 64'(ifid_flush), 64'(1));
      chk("redir_bubble", 64'(idex_bubble), 64'(1));
      cycle("redir");
      ex_redirect = 1'b0;
      chk("redir_stall_same", 64'(stall_cycles), 64'(sat_base));
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 9);
      cycle("w9_wb");
      set_wb(0, 0);

      // Halt with r3 still pending
      set_id(1, 0, 0, 0, 0, 3, 1, 0);
      cycle("w3");
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("halt_issue", 64'(issue), 64'(1));
      cycle("halt");
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_done_low", 64'(done), 64'(0));
         chk("drain_pc_en", 64'(pc_en), 64'(0));
         cycle("drain");
      end
      set_wb(1, 3);
      cycle("drain_wb3");
      set_wb(0, 0);
      #1;
      chk("drain_last_done", 64'(done), 64'(0));
      cycle("drain_last");
      chk("halt_done", 64'(done), 64'(1));
      chk("done_pc_en", 64'(pc_en), 64'(0));
      start = 1'b1;
      cycle("done_start");
      start = 1'b0;
      chk("done_sticky", 64'(done), 64'(1));

      // Reset in the middle of a stall
      do_reset("r1");
      start_run();
      set_id(1, 0, 0, 0, 0, 9, 1, 0);
      cycle("w9b");
      set_id(1, 0, 0, 9, 1, 0, 0, 0);
      repeat (3) cycle("stall_pre_rst");
      do_reset("mid_stall");

      // Stall counter saturation
      start_run();
      set_id(1, 0, 0, 0, 0, 9, 1, 0);
      cycle("w9c");
      set_id(1, 9, 1, 0, 0, 0, 0, 0);
      repeat (STALL_MAX + 3) cycle("sat");
      chk("stall_saturated", 64'(stall_cycles), 64'(16'hFFFF));
      do_reset("r2");

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 4000; n++) begin
         if (m_state == M_DONE || $urandom_range(0, 999) == 0) begin
            do_reset("rnd_rst");
         end
         start       = ($urandom_range(0, 19) == 0);
         ex_redirect = ($urandom_range(0, 9) == 0);
         set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 99) == 0);
         set_wb(0, $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            int s;
            s = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
               if (!wb_reg_wrt && m_pend[(s + k) % 8]) set_wb(1, (s + k) % 8);
            end
         end
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
